// File: rtl/sr_ff_driver.sv
// sr_ff_driver: initiator side of an S/R flip-flop link.
// Accepts target bits and drives S/R from the excitation table against the flop's Q feedback.
// It then waits a settle window and checks Q against the target.
// Optional mismatch checking (err / err_cnt) is built only when SR_DRV_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | ready for a target (in_ready=1 once out of reset)
// DRIVE  | S/R asserted for exactly one cycle
// SETTLE | S=R=0 for SETTLE_CYC cycles while the flop settles
// CHECK  | one cycle; at its closing edge Q is compared and done pulses
module sr_ff_driver #(
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  input  logic             q_fb,
  output logic             s_out,
  output logic             r_out,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             clr_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t     state;
  logic       target;
  logic [3:0] settle_cnt;

  // Sequencing FSM with registered S/R, ready and done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= 1'b0;
      settle_cnt <= 4'd0;
      s_out      <= 1'b0;
      r_out      <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            target   <= in_data;
            // Excitation table: set only on 0->1, reset only on 1->0, never both
            s_out    <= in_data & ~q_fb;
            r_out    <= ~in_data & q_fb;
            in_ready <= 1'b0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          s_out      <= 1'b0;
          r_out      <= 1'b0;
          settle_cnt <= 4'(SETTLE_CYC - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) state <= CHECK;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_DRV_CHECK_EN
  logic mismatch;
  assign mismatch = (state == CHECK) && (q_fb != target);

  // Mismatch pulse and saturating counter; a clear beats a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= mismatch;
      if (clr_err) err_cnt <= '0;
      else if (mismatch && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = clr_err ^ target;
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver: an SR flop model on the S/R link, plus a transaction-level reference model.
// One compare process checks the DUT against the reference every cycle.
// Directed literal checks and a randomized phase follow.
module tb_sr_ff_driver;
  localparam int N     = 3;
  localparam int ERR_W = 3;
  localparam int MAXC  = (1 << ERR_W) - 1;
`ifdef SR_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_data, in_ready, q_fb, s_out, r_out, done, err, clr_err;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  // external flop model, optionally stuck
  logic ff_q = 1'b0;
  logic stuck = 1'b0;
  logic stuck_val = 1'b0;
  assign q_fb = stuck ? stuck_val : ff_q;

  sr_ff_driver #(.SETTLE_CYC(N), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .q_fb(q_fb), .s_out(s_out), .r_out(r_out), .done(done), .err(err), .err_cnt(err_cnt),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_out) ff_q <= 1'b1;
    else if (r_out) ff_q <= 1'b0;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  a_sr_excl: assert property (@(posedge clk) !(s_out && r_out))
    else $error("FAIL a_sr_excl s_out and r_out both 1");

  // Reference model: each accepted target completes exactly N+2 edges later
  int   edge_k, acc;
  bit   busy, m_ready, m_tgt, m_done, m_err, m_mis;
  logic [1:0] m_sr;
  int   m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_k = 0; acc = 0; busy = 0; m_ready = 0; m_tgt = 0;
      m_sr = 2'b00; m_done = 0; m_err = 0; m_cnt = 0;
    end else begin
      edge_k++;
      m_done = 0; m_err = 0; m_mis = 0; m_sr = 2'b00;
      if (busy) begin
        if (edge_k - acc == N + 2) begin
          busy = 0; m_done = 1;
          m_mis = CHK && (q_fb != m_tgt);
          m_err = m_mis;
        end
      end else if (m_ready && in_valid) begin
        busy = 1; acc = edge_k; m_tgt = in_data;
        if (in_data == q_fb) m_sr = 2'b00;
        else if (in_data) m_sr = 2'b10;
        else m_sr = 2'b01;
      end
      if (CHK) begin
        if (clr_err) m_cnt = 0;
        else if (m_mis && m_cnt < MAXC) m_cnt++;
      end
      m_ready = !busy;
    end
  end

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    chk("cyc_s_out", s_out, m_sr[1]);
    chk("cyc_r_out", r_out, m_sr[0]);
    chk("cyc_in_ready", in_ready, m_ready);
    chk("cyc_done", done, m_done);
    chk("cyc_err", err, m_err);
    chk("cyc_err_cnt", err_cnt, m_cnt);
    chk("cyc_sr_excl", s_out & r_out, 0);
  end

  logic [1:0] sr0;
  int lat;
  bit e;

  // Offer one target (called at a negedge); reports first S/R, latency and err at done
  task automatic send(input bit d, input bit clr_d, output logic [1:0] sr_first,
                      output int lt, output bit ev);
    int w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    sr_first = 2'b00; lt = -1; ev = 0;
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1; in_data = d; clr_err = clr_d;
    @(negedge clk);
    in_valid = 1'b0; in_data = 1'($urandom);
    sr_first = {s_out, r_out};
    lt = 0;
    while (lt < 40) begin
      @(negedge clk); lt++;
      if (done) begin ev = err; break; end
    end
    if (lt >= 40) chk("done_timeout", 0, 1);
    clr_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {s_out, r_out, in_ready, done, err}, 5'b0);
    chk("rst_cnt", err_cnt, 0);
    rst_n = 1'b1;
    #1 chk("rel_ready0", in_ready, 0);
    @(negedge clk);
    chk("rel_ready1", in_ready, 1);
    chk("rel_sr", {s_out, r_out}, 2'b00);

    // set, reset, hold
    send(1'b1, 1'b0, sr0, lat, e);
    chk("set_sr", sr0, 2'b10); chk("set_lat", lat, N + 2); chk("set_err", e, 0);
    send(1'b0, 1'b0, sr0, lat, e);
    chk("rst_sr", sr0, 2'b01); chk("rst_lat", lat, N + 2);
    send(1'b0, 1'b0, sr0, lat, e);
    chk("hold_sr", sr0, 2'b00); chk("hold_lat", lat, N + 2); chk("hold_err", e, 0);

    // stuck-at-0 mismatches
    stuck = 1'b1; stuck_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, sr0, lat, e);
      chk("mis_err", e, CHK);
    end
    chk("mis_cnt5", err_cnt, CHK ? 5 : 0);
    send(1'b1, 1'b1, sr0, lat, e);
    chk("clr_wins_err", e, CHK);
    chk("clr_wins_cnt", err_cnt, 0);
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, sr0, lat, e);
    chk("sat_cnt", err_cnt, CHK ? MAXC : 0);
    stuck = 1'b0;

    // reset during SETTLE
    send(1'b1, 1'b0, sr0, lat, e);
    @(negedge clk);
    in_valid = 1'b1; in_data = ~ff_q;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outs", {s_out, r_out, in_ready, done, err}, 5'b0);
    chk("midrst_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(~ff_q, 1'b0, sr0, lat, e);
    chk("post_rst_lat", lat, N + 2);
    chk("post_rst_err", e, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        clr_err = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
      clr_err = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        stuck = 1'($urandom); stuck_val = 1'($urandom);
      end
      send(1'($urandom), $urandom_range(0, 7) == 0, sr0, lat, e);
      chk("rnd_lat", lat, N + 2);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
